// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port, one tenure at a time.
// Optional bus watchdog is compiled in when WB_ARB_TIMEOUT_EN is defined.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  output logic [NUM_MASTERS-1:0]            gnt_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  logic [0:0]             state;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       last_owner;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [IDX_W-1:0]       pick;
  logic                   pick_valid;
  logic                   owned;
  logic                   timeout_hit;

  assign owned = (state == OWNED);

  // Rotating priority: the search starts just after the previous owner and wraps.
  always_comb begin
    int j;
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    pick       = '0;
    pick_valid = 1'b0;
    j          = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      j = int'(last_owner) + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (!pick_valid && m_cyc_i[j]) begin
        pick       = IDX_W'(j);
        pick_valid = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_MASTERS - 1);
      gnt_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= OWNED;
            owner <= pick;
            gnt_q <= NUM_MASTERS'(1) << pick;
          end
        end
        OWNED: begin
          if (!m_cyc_i[owner]) begin
            state      <= IDLE;
            last_owner <= owner;
            gnt_q      <= '0;
          end
        end
        default: begin
          state <= IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TO_W-1:0] to_cnt;
  logic            strobing;

  assign strobing    = owned & m_cyc_i[owner] & m_stb_i[owner];
  assign timeout_hit = strobing && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Counts strobed cycles the slave leaves unanswered; restarts on any response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      to_cnt <= '0;
    end else if (timeout_hit || !strobing || s_ack_i || s_err_i) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Slave side follows the owner only while OWNED; reset clears state, so it drops asynchronously.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (owned) begin
      s_cyc_o = m_cyc_i[owner];
      s_stb_o = m_cyc_i[owner] & m_stb_i[owner] & ~timeout_hit;
      s_we_o  = m_we_i[owner];
      s_adr_o = m_adr_i[owner*ADDR_WIDTH +: ADDR_WIDTH];
      s_dat_o = m_dat_i[owner*DATA_WIDTH +: DATA_WIDTH];
      s_sel_o = m_sel_i[owner*SEL_WIDTH +: SEL_WIDTH];
    end
  end

  assign m_dat_o = s_dat_i;
  assign m_ack_o = {NUM_MASTERS{s_ack_i}} & gnt_q & m_stb_i;
  assign m_err_o = ({NUM_MASTERS{s_err_i}} & gnt_q & m_stb_i)
                 | ({NUM_MASTERS{timeout_hit}} & gnt_q);
  assign gnt_o   = gnt_q;

endmodule
